// File: rtl/control_sequencer.sv
// control_sequencer: T-state sequencer and opcode decoder for the 4-bit processor.
// State advances on the falling edge of MainClock, so the combinational control
// word is settled through the following high phase when registers gate-latch.
// Optional build macro: CONTROL_SINGLE_STEP_EN (adds StepReq single-step debug).
// T_STATES must be at least 6 (3 fetch + 3 execute) and at most 8 (3-bit TState).
module control_sequencer #(
  parameter int T_STATES = 6,
  parameter int OPW      = 4
) (
  input  logic           MainClock,
  input  logic           ClearControlN,
  input  logic           Run,
  input  logic [OPW-1:0] Opcode,
  input  logic           AccZero,
`ifdef CONTROL_SINGLE_STEP_EN
  input  logic           StepReq,
`endif
  output logic           ClearInstrReg,
  output logic           LatchInstrReg,
  output logic           EnableInstrReg,
  output logic           PcEnable,
  output logic           PcInc,
  output logic           PcLoad,
  output logic           LatchMar,
  output logic           RamEnable,
  output logic           LatchAcc,
  output logic           EnableAcc,
  output logic           LatchB,
  output logic           AluSub,
  output logic           EnableAlu,
  output logic           LatchOut,
  output logic           Halted,
  output logic [2:0]     TState
);

  localparam logic [OPW-1:0] OP_LDA = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB = OPW'(2);
  localparam logic [OPW-1:0] OP_JMP = OPW'(3);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(4);
  localparam logic [OPW-1:0] OP_OUT = OPW'(14);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  localparam logic [2:0] T_LAST = 3'(T_STATES - 1);

  typedef enum logic {
    SEQ  = 1'b0,
    HALT = 1'b1
  } mode_t;

  mode_t      mode;
  logic [2:0] tstate;
  logic       advance;
  logic       out_en;

`ifdef CONTROL_SINGLE_STEP_EN
  logic step_q;

  // Remember last StepReq so a held request advances only once.
  always_ff @(negedge MainClock or negedge ClearControlN) begin
    if (!ClearControlN) step_q <= 1'b0;
    else                step_q <= StepReq;
  end

  // While frozen, the control word stays visible for single-step debug.
  assign advance = Run | (StepReq & ~step_q);
  assign out_en  = ClearControlN;
`else
  assign advance = Run;
  assign out_en  = ClearControlN & Run;
`endif

  assign ClearInstrReg = ~ClearControlN;
  assign TState        = tstate;

  // T-counter and halt latch; HALT is left only through reset.
  always_ff @(negedge MainClock or negedge ClearControlN) begin
    if (!ClearControlN) begin
      mode   <= SEQ;
      tstate <= '0;
    end else if (mode == SEQ && advance) begin
      if (tstate == 3'd3 && Opcode == OP_HLT) begin
        mode <= HALT;
      end else if (tstate == T_LAST) begin
        tstate <= '0;
      end else begin
        tstate <= tstate + 3'd1;
      end
    end
  end

  // Control word decode from the registered T-state and current opcode.
  always_comb begin
    LatchInstrReg  = 1'b0;
    EnableInstrReg = 1'b0;
    PcEnable       = 1'b0;
    PcInc          = 1'b0;
    PcLoad         = 1'b0;
    LatchMar       = 1'b0;
    RamEnable      = 1'b0;
    LatchAcc       = 1'b0;
    EnableAcc      = 1'b0;
    LatchB         = 1'b0;
    AluSub         = 1'b0;
    EnableAlu      = 1'b0;
    LatchOut       = 1'b0;
    Halted         = 1'b0;
    if (mode == HALT) begin
      Halted = 1'b1;
    end else if (out_en) begin
      case (tstate)
        3'd0: begin
          PcEnable = 1'b1;
          LatchMar = 1'b1;
        end
        3'd1: PcInc = 1'b1;
        3'd2: begin
          RamEnable     = 1'b1;
          LatchInstrReg = 1'b1;
        end
        3'd3: begin
          case (Opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              EnableInstrReg = 1'b1;
              LatchMar       = 1'b1;
            end
            OP_JMP: begin
              EnableInstrReg = 1'b1;
              PcLoad         = 1'b1;
            end
            OP_JZ: begin
              EnableInstrReg = AccZero;
              PcLoad         = AccZero;
            end
            OP_OUT: begin
              EnableAcc = 1'b1;
              LatchOut  = 1'b1;
            end
            OP_HLT:  Halted = 1'b1;
            default: ;
          endcase
        end
        3'd4: begin
          case (Opcode)
            OP_LDA: begin
              RamEnable = 1'b1;
              LatchAcc  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              RamEnable = 1'b1;
              LatchB    = 1'b1;
              AluSub    = (Opcode == OP_SUB);
            end
            default: ;
          endcase
        end
        3'd5: begin
          if (Opcode == OP_ADD || Opcode == OP_SUB) begin
            EnableAlu = 1'b1;
            LatchAcc  = 1'b1;
            AluSub    = (Opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Timing-and-control unit for the 4-bit processor.
- Steps a 6-state T-counter and decodes the opcode held in the instruction register. Drives the one-hot control word that sequences the instruction register, program counter, MAR, RAM, accumulator, B register, ALU and output port.
- The instruction register's latch, enable and clear lines are owned by this block.

Parameters:
- T_STATES, 6, number of T-states per instruction (3 fetch + 3 execute). Values below 6 are illegal.
- OPW, 4, opcode width (instruction register upper nibble).

Ports:
- MainClock  in  1  system clock. T-state advances on the falling edge; control outputs are stable through the high phase, when registers gate-latch.
- ClearControlN  in  1  asynchronous, active-low reset.
- Run  in  1  1 = sequence; 0 = freeze the T-state, with all control outputs except ClearInstrReg forced to 0.
- Opcode  in  OPW  from the instruction register outputs ToInstr3..ToInstr0.
- AccZero  in  1  accumulator == 0 flag, used by JZ.
- ClearInstrReg  out  1  instruction register clear (active high).
- LatchInstrReg  out  1  instruction register load.
- EnableInstrReg  out  1  drive the instruction register operand nibble onto the bus.
- PcEnable / PcInc / PcLoad  out  1 each  program counter bus drive / increment / load.
- LatchMar  out  1  MAR load.
- RamEnable  out  1  RAM bus drive.
- LatchAcc / EnableAcc  out  1 each  accumulator load / bus drive.
- LatchB  out  1  B register load.
- AluSub  out  1  ALU subtract select.
- EnableAlu  out  1  ALU bus drive.
- LatchOut  out  1  output register load.
- Halted  out  1  processor stopped.
- TState  out  3  current T-state index, 0..5.

Behaviour:
- Reset (ClearControlN=0, asynchronous):
  - TState=0, Halted=0.
  - All control outputs 0, except ClearInstrReg=1.
  - ClearInstrReg = NOT ClearControlN, combinational, asserted independently of Run.
- On reset release, the first falling edge with Run=1 leaves T0.
- Control outputs are combinational decodes of the registered state (TState, Halted, Opcode, AccZero). No glitches are allowed on a stable state.
- Bus-drive exclusivity: at most one of PcEnable, EnableInstrReg, RamEnable, EnableAcc, EnableAlu is 1 in any state.
- Fetch, for every opcode:
  - T0: PcEnable, LatchMar.
  - T1: PcInc.
  - T2: RamEnable, LatchInstrReg.
- Execute by opcode. Lines not listed are 0.
  - LDA 0000: T3 EnableInstrReg+LatchMar; T4 RamEnable+LatchAcc; T5 none.
  - ADD 0001: T3 EnableInstrReg+LatchMar; T4 RamEnable+LatchB; T5 EnableAlu+LatchAcc.
  - SUB 0010: as ADD, with AluSub=1 during T4 and T5.
  - JMP 0011: T3 EnableInstrReg+PcLoad.
  - JZ 0100: T3 EnableInstrReg+PcLoad only if AccZero=1, otherwise none.
  - OUT 1110: T3 EnableAcc+LatchOut.
  - HLT 1111: at T3, Halted=1 and all control lines 0. The next falling edge enters HALT.
  - Any other opcode: NOP, no control lines in T3-T5.
- T-state wrap: T5 -> T0. The cycle length is always T_STATES, including for short instructions (fixed-length machine cycle).
- HALT state:
  - TState frozen at 3, Halted=1, all control lines 0.
  - Ignores Run and Opcode.
  - Exit only through ClearControlN.
- Run deasserted mid-instruction:
  - TState holds; outputs are 0 while Run=0.
  - On Run=1 the decode of the held TState resumes; no state is skipped or repeated.
- Reset asserted mid-instruction: immediate return to T0, Halted=0, instruction abandoned.
- Opcode is sampled only via the decode in T3-T5. Changes during T0-T2 have no effect on fetch outputs.

Optional Feature:
- Macro: CONTROL_SINGLE_STEP_EN.
- When defined:
  - Adds input StepReq (1 bit).
  - With Run=0, a 0->1 transition of StepReq, sampled on the falling edge of MainClock, advances exactly one T-state.
  - Control outputs of the current T-state are driven while Run=0 (single-step debug), instead of being forced to 0.
  - StepReq held high advances only once per rising transition.
- When undefined:
  - No StepReq port.
  - Run=0 freezes with outputs forced to 0, as above.

Test Plan:
- Reset then Run=1, Opcode=0000 (LDA), AccZero=0 -> TState 0,1,2,3,4,5,0 on successive falling edges. T0 PcEnable+LatchMar, T2 RamEnable+LatchInstrReg, T4 RamEnable+LatchAcc. ClearInstrReg=0 after release.
- Opcode=0010 (SUB) -> T4 LatchB=1, AluSub=1; T5 EnableAlu=1, LatchAcc=1, AluSub=1. Bus-drive lines are one-hot or zero in every cycle.
- Opcode=0100 with AccZero=0 -> no PcLoad in T3. Repeat with AccZero=1 -> PcLoad=1 and EnableInstrReg=1 in T3 only.
- Opcode=1111 -> Halted=1 from T3. TState stays 3 for 20 clocks with Run toggling, all controls 0. Pulse ClearControlN low mid-cycle (asynchronous, no clock edge) -> TState=0, Halted=0, ClearInstrReg=1 immediately.
- Run=0 at T4 for 5 clocks -> TState stays 4, outputs 0. Run=1 -> T4 outputs reappear, then T5.
- With CONTROL_SINGLE_STEP_EN: Run=0, three StepReq pulses -> TState 0->1->2->3, with T-state controls visible. StepReq held high for 4 clocks -> single advance.
